// File: rtl/fetch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_sequencer
// Purpose  : Holds the architectural fetch PC for the pipelined Thumb core.
//            It presents one fetch address per cycle to instruction memory and
//            advances the PC on each accepted fetch. Redirects from the
//            execute-stage branch logic load a new PC and hold the pipeline
//            flush high for a fixed window.
// Ports    : clk_i, reset_i            - clock, asynchronous active-high reset
//            take_branch_i            - redirect request
//            branch_target_i [WORD]   - redirect target (bit 0 is cleared)
//            stall_i                  - hazard stall; PC is held
//            imem_ready_i             - memory accepts the presented address
//            pc_o [WORD]              - current fetch address
//            fetch_valid_o            - pc_o is a valid fetch request
//            flush_pipeline_o         - squash fetch/decode contents
//            redirect_count_o [CNT_W] - saturating count of accepted redirects
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_sequencer #(
   parameter int unsigned      WORD         = 32,
   parameter logic [WORD-1:0]  RESET_VECTOR = '0,
   parameter int unsigned      INST_BYTES   = 2,
   parameter int unsigned      FLUSH_CYCLES = 2,
   parameter int unsigned      CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             take_branch_i,
   input  logic [WORD-1:0]  branch_target_i,
   input  logic             stall_i,
   input  logic             imem_ready_i,
   output logic [WORD-1:0]  pc_o,
   output logic             fetch_valid_o,
   output logic             flush_pipeline_o,
   output logic [CNT_W-1:0] redirect_count_o
);

   typedef enum logic [1:0] {
      S_BOOT     = 2'd0,
      S_FETCH    = 2'd1,
      S_REDIRECT = 2'd2
   } state_t;

   // Flush-window cycles still to spend in S_REDIRECT after the accept cycle.
   localparam logic [3:0]      c_FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [WORD-1:0] c_PC_INC       = WORD'(INST_BYTES);
   // Mask clearing the Thumb bit of a branch target.
   localparam logic [WORD-1:0] c_ALIGN_MASK   = ~(WORD'(1));

   state_t           state_q, state_d;
   logic [WORD-1:0]  pc_q, pc_d;
   logic [3:0]       flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

   logic             w_redirect;
   logic             w_fetch_accept;

   // Branches are honoured only once the sequencer is out of BOOT.
   assign w_redirect     = take_branch_i &
                           ((state_q == S_FETCH) || (state_q == S_REDIRECT));
   assign w_fetch_accept = (state_q == S_FETCH) & imem_ready_i &
                           ~stall_i & ~take_branch_i;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      flush_cnt_d = flush_cnt_q;
      redir_cnt_d = redir_cnt_q;

      if (w_redirect) begin
         // Redirect outranks stall and memory back-pressure; the newest
         // target wins even while an earlier flush window is still open.
         pc_d = branch_target_i & c_ALIGN_MASK;
         if (redir_cnt_q != {CNT_W{1'b1}}) begin
            redir_cnt_d = redir_cnt_q + 1'b1;
         end
         if (FLUSH_CYCLES == 1) begin
            state_d     = S_FETCH;
            flush_cnt_d = '0;
         end else begin
            state_d     = S_REDIRECT;
            flush_cnt_d = c_FLUSH_RELOAD;
         end
      end else begin
         case (state_q)
            S_BOOT: begin
               state_d = S_FETCH;
            end
            S_FETCH: begin
               if (w_fetch_accept) begin
                  pc_d = pc_q + c_PC_INC;
               end
            end
            S_REDIRECT: begin
               flush_cnt_d = flush_cnt_q - 1'b1;
               if (flush_cnt_q <= 4'd1) begin
                  state_d     = S_FETCH;
                  flush_cnt_d = '0;
               end
            end
            default: begin
               state_d     = S_BOOT;
               flush_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_BOOT;
         pc_q        <= RESET_VECTOR;
         flush_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         flush_cnt_q <= flush_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign pc_o             = pc_q;
   assign fetch_valid_o    = (state_q == S_FETCH);
   // The accept cycle flushes combinationally; the rest of the window is
   // covered by the registered REDIRECT state.
   assign flush_pipeline_o = (state_q == S_REDIRECT) | w_redirect;
   assign redirect_count_o = redir_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_sequencer
// Purpose  : Self-checking bench for fetch_pc_sequencer. Per-cycle expected
//            pc/valid/flush values are queued as stimulus is applied and
//            compared on the falling edge. A second instance with a 4-bit
//            redirect counter shares the stimulus to observe saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_sequencer;

   localparam int unsigned WORD = 32;

   logic            clk_i = 1'b0;
   logic            reset_i = 1'b1;
   logic            take_branch_i = 1'b0;
   logic [WORD-1:0] branch_target_i = '0;
   logic            stall_i = 1'b0;
   logic            imem_ready_i = 1'b0;
   logic [WORD-1:0] pc_o, pc_sat;
   logic            fetch_valid_o, valid_sat;
   logic            flush_pipeline_o, flush_sat;
   logic [15:0]     redirect_count_o;
   logic [3:0]      count_sat;

   typedef struct packed {
      logic [WORD-1:0] pc;
      logic            valid;
      logic            flush;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk_i = ~clk_i;

   fetch_pc_sequencer #(
      .WORD(32), .RESET_VECTOR(32'h0), .INST_BYTES(2),
      .FLUSH_CYCLES(2), .CNT_W(16)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .take_branch_i(take_branch_i),
      .branch_target_i(branch_target_i), .stall_i(stall_i),
      .imem_ready_i(imem_ready_i), .pc_o(pc_o), .fetch_valid_o(fetch_valid_o),
      .flush_pipeline_o(flush_pipeline_o), .redirect_count_o(redirect_count_o)
   );

   fetch_pc_sequencer #(
      .WORD(32), .RESET_VECTOR(32'h0), .INST_BYTES(2),
      .FLUSH_CYCLES(2), .CNT_W(4)
   ) dut_sat (
      .clk_i(clk_i), .reset_i(reset_i), .take_branch_i(take_branch_i),
      .branch_target_i(branch_target_i), .stall_i(stall_i),
      .imem_ready_i(imem_ready_i), .pc_o(pc_sat), .fetch_valid_o(valid_sat),
      .flush_pipeline_o(flush_sat), .redirect_count_o(count_sat)
   );

   task automatic check_eq(input string tag, input logic [WORD-1:0] act,
                           input logic [WORD-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs just after the rising edge and queue the
   // outputs expected for the remainder of that cycle.
   task automatic cyc(input logic rs, input logic tk, input logic [WORD-1:0] tgt,
                      input logic st, input logic rdy,
                      input logic [WORD-1:0] epc, input logic ev, input logic ef);
      exp_t e;
      @(posedge clk_i);
      #1;
      reset_i         = rs;
      take_branch_i   = tk;
      branch_target_i = tgt;
      stall_i         = st;
      imem_ready_i    = rdy;
      e.pc    = epc;
      e.valid = ev;
      e.flush = ef;
      sb.push_back(e);
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq("pc", pc_o, e.pc);
         check_eq("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, e.valid});
         check_eq("flush", {31'b0, flush_pipeline_o}, {31'b0, e.flush});
      end
   end

   initial begin
      // Reset and BOOT
      cyc(1, 0, 0, 0, 0, 32'h0, 0, 0);
      cyc(1, 0, 0, 0, 0, 32'h0, 0, 0);
      check_eq("reset_count", {16'b0, redirect_count_o}, 32'h0);
      cyc(0, 0, 0, 0, 1, 32'h0, 0, 0);
      // Sequential fetch 0x0 .. 0xE
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 0, 1, 32'(2 * i), 1, 0);
      end
      // Redirect at 0x10 to 0x101 -> 0x100
      cyc(0, 1, 32'h0000_0101, 0, 1, 32'h10, 1, 1);
      cyc(0, 0, 0, 0, 1, 32'h100, 0, 1);
      cyc(0, 0, 0, 0, 1, 32'h100, 1, 0);
      cyc(0, 0, 0, 0, 1, 32'h102, 1, 0);
      check_eq("count_after_1", {16'b0, redirect_count_o}, 32'd1);
      // Move to 0x20, then stall and memory back-pressure
      cyc(0, 1, 32'h21, 0, 1, 32'h104, 1, 1);
      cyc(0, 0, 0, 0, 1, 32'h20, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 32'h20, 1, 0);
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 32'h20, 1, 0);
      cyc(0, 0, 0, 0, 1, 32'h20, 1, 0);
      // Back-to-back redirects under stall; 0x300 wins
      cyc(0, 1, 32'h200, 1, 1, 32'h22, 1, 1);
      check_eq("count_after_2", {16'b0, redirect_count_o}, 32'd2);
      cyc(0, 1, 32'h300, 1, 1, 32'h200, 0, 1);
      cyc(0, 0, 0, 1, 1, 32'h300, 0, 1);
      cyc(0, 0, 0, 1, 1, 32'h300, 1, 0);
      check_eq("count_after_4", {16'b0, redirect_count_o}, 32'd4);
      cyc(0, 0, 0, 0, 1, 32'h300, 1, 0);
      // PC wrap from 0xFFFF_FFFE
      cyc(0, 1, 32'hFFFF_FFFF, 0, 1, 32'h302, 1, 1);
      cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 1);
      cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 1, 0);
      cyc(0, 0, 0, 0, 1, 32'h0, 1, 0);
      check_eq("count_after_5", {16'b0, redirect_count_o}, 32'd5);
      check_eq("sat_count_5", {28'b0, count_sat}, 32'd5);
      // 20 consecutive redirects: narrow counter saturates
      for (int i = 0; i < 20; i++) begin
         cyc(0, 1, 32'h400, 0, 1, (i == 0) ? 32'h2 : 32'h400, (i == 0), 1);
      end
      cyc(0, 0, 0, 0, 1, 32'h400, 0, 1);
      cyc(0, 0, 0, 0, 0, 32'h400, 1, 0);
      check_eq("count_after_25", {16'b0, redirect_count_o}, 32'd25);
      check_eq("sat_count_max", {28'b0, count_sat}, 32'hF);
      // Asynchronous reset in the middle of a redirect window
      cyc(0, 1, 32'h500, 0, 0, 32'h400, 1, 1);
      @(posedge clk_i);
      #1;
      take_branch_i = 1'b0;
      check_eq("mid_redirect_pc", pc_o, 32'h500);
      check_eq("mid_redirect_flush", {31'b0, flush_pipeline_o}, 32'd1);
      #1;
      reset_i = 1'b1;
      #1;
      check_eq("async_pc", pc_o, 32'h0);
      check_eq("async_valid", {31'b0, fetch_valid_o}, 32'd0);
      check_eq("async_flush", {31'b0, flush_pipeline_o}, 32'd0);
      check_eq("async_count", {16'b0, redirect_count_o}, 32'd0);
      check_eq("async_sat_count", {28'b0, count_sat}, 32'd0);
      cyc(1, 0, 0, 0, 1, 32'h0, 0, 0);
      // BOOT repeats; a branch offered in BOOT is ignored
      cyc(0, 1, 32'h600, 0, 1, 32'h0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h0, 1, 0);
      cyc(0, 0, 0, 0, 1, 32'h2, 1, 0);
      check_eq("boot_branch_ignored", {16'b0, redirect_count_o}, 32'd0);
      @(negedge clk_i);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Owns the architectural fetch PC and sequences instruction fetch for the pipelined Thumb core. It accepts redirect requests from the execute-stage branch logic (take-branch plus target) and stall requests from the hazard unit. It handshakes each fetch with instruction memory and drives pipeline flush for a fixed window after every redirect. It sits between the branch logic, the hazard unit and the instruction-memory port.

Parameters:
WORD, 32, datapath and PC width in bits
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
INST_BYTES, 2, PC increment per accepted fetch (Thumb halfword)
FLUSH_CYCLES, 2, cycles flush_pipeline_o stays high per redirect, including the accept cycle; legal range 1..15
CNT_W, 16, width of the redirect performance counter

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
take_branch_i  in  1  redirect request from execute-stage branch logic
branch_target_i  in  WORD  redirect target address
stall_i  in  1  hazard-unit stall; hold the PC
imem_ready_i  in  1  instruction memory accepts the presented address this cycle
pc_o  out  WORD  current fetch address
fetch_valid_o  out  1  pc_o is a valid fetch request
flush_pipeline_o  out  1  squash fetch and decode stage contents
redirect_count_o  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset (async assert, sync release): state=BOOT, pc_o=RESET_VECTOR, fetch_valid_o=0, flush_pipeline_o=0, redirect_count_o=0, flush counter=0.
- States: BOOT, FETCH, REDIRECT.
- BOOT: lasts one cycle with fetch_valid_o=0. Next state is FETCH, with pc unchanged. A take_branch_i in BOOT is ignored.
- FETCH: fetch_valid_o=1.
  - Fetch accepted when fetch_valid_o & imem_ready_i & ~stall_i & ~take_branch_i. On accept, pc <= pc + INST_BYTES, modulo 2^WORD. 32'hFFFF_FFFE wraps to 32'h0.
  - stall_i=1 or imem_ready_i=0: pc held and fetch_valid_o stays 1, so the same address is re-presented.
- Redirect accept: take_branch_i=1 in FETCH or REDIRECT.
  - Redirect has priority over stall_i and imem_ready_i.
  - In the accept cycle T, flush_pipeline_o=1 (combinational from take_branch_i).
  - At T+1: pc <= {branch_target_i[WORD-1:1],1'b0}. Bit 0 is the Thumb bit and is always cleared.
  - redirect_count_o increments by 1 and saturates at all-ones.
  - If FLUSH_CYCLES=1, next state is FETCH.
  - Otherwise, next state is REDIRECT with the flush counter loaded to FLUSH_CYCLES-1.
- REDIRECT: fetch_valid_o=0 and flush_pipeline_o=1 (registered). pc holds the target.
  - Counter decrements each cycle. After FLUSH_CYCLES-1 cycles in REDIRECT, the state becomes FETCH and the first target fetch is presented at T+FLUSH_CYCLES.
  - stall_i and imem_ready_i are ignored in REDIRECT.
  - A new take_branch_i during REDIRECT is accepted with the same rules: the newest target wins, the counter reloads, and the count increments.
- Outputs pc_o, fetch_valid_o and redirect_count_o are registered or state-decoded with no combinational input path. flush_pipeline_o has a combinational path from take_branch_i only in FETCH and REDIRECT.
- Reset asserted mid-REDIRECT or mid-stall immediately returns all outputs to reset values. No pending redirect survives reset.

Test Plan:
- Reset, then imem_ready_i=1 with no stall. Expect: T0 BOOT with fetch_valid_o=0 and pc 0x0; then pc 0x0, 0x2, 0x4, 0x6 on consecutive cycles with fetch_valid_o=1.
- In FETCH at pc 0x10, take_branch_i=1 with target 0x0000_0101 (FLUSH_CYCLES=2). Expect: flush=1 in cycles T and T+1; fetch_valid_o=0 at T+1; pc 0x100 with fetch_valid_o=1 at T+2; then 0x102; count=1.
- stall_i=1 for 3 cycles at pc 0x20, then imem_ready_i=0 for 2 cycles. Expect: pc held at 0x20 with fetch_valid_o=1 throughout; advances to 0x22 once both are released.
- take_branch_i with target 0x200 at T, and with target 0x300 at T+1 (during REDIRECT), while stall_i=1 for the whole window. Expect: flush continuous T..T+2; fetch at 0x300 at T+3; 0x200 never fetched; count=2.
- Force the pc to 0xFFFF_FFFE via a redirect, then accept one fetch. Expect: pc wraps to 0x0000_0000. Separately, CNT_W=4 with 20 redirects: redirect_count_o saturates at 4'hF.
- Assert reset_i asynchronously mid-REDIRECT. Expect: flush_pipeline_o, fetch_valid_o and redirect_count_o drop to 0 and pc_o returns to RESET_VECTOR before the next clock edge; BOOT sequence repeats after release.
